// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 types, GF(2^8) arithmetic, round and key-schedule primitives.
// Latency: none. Everything here is a pure combinational function.
// Backpressure: not applicable. There is no state and no handshake.
// Byte order everywhere: bit 127 is byte 0; byte 4*c+r is row r of column c.
package aes_pkg;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;
  typedef logic [3:0]   round_t;

  localparam round_t NR = 4'd10;

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic byte_t gf_mul(input byte_t a, input byte_t b);
    byte_t acc;
    byte_t x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  function automatic byte_t mul9(input byte_t b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic byte_t mul11(input byte_t b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic byte_t mul13(input byte_t b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic byte_t mul14(input byte_t b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  // Computes a^254, which is the multiplicative inverse. Zero maps to zero.
  function automatic byte_t gf_inv(input byte_t a);
    byte_t sq;
    byte_t acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic byte_t rotl8(input byte_t b, input int unsigned n);
    byte_t r;
    r = b;
    for (int unsigned i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // The S-boxes are derived from the field inverse and the affine map
  // rather than stored as tables.
  function automatic byte_t sbox(input byte_t b);
    byte_t v;
    v = gf_inv(b);
    return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
  endfunction

  function automatic byte_t inv_sbox(input byte_t s);
    return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
  endfunction

  // SubWord(RotWord(w))
  function automatic word_t sub_rot_word(input word_t w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic block_t inv_shift_rows(input block_t s);
    block_t o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
    return o;
  endfunction

  function automatic block_t inv_sub_bytes(input block_t s);
    block_t o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = inv_sbox(s[127 - 8*i -: 8]);
    return o;
  endfunction

  function automatic block_t inv_mix_columns(input block_t s);
    block_t o;
    byte_t  a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 32] = {mul14(a0) ^ mul11(a1) ^ mul13(a2) ^ mul9(a3),
                             mul9(a0)  ^ mul14(a1) ^ mul11(a2) ^ mul13(a3),
                             mul13(a0) ^ mul9(a1)  ^ mul14(a2) ^ mul11(a3),
                             mul11(a0) ^ mul13(a1) ^ mul9(a2)  ^ mul14(a3)};
    end
    return o;
  endfunction

  function automatic byte_t rcon(input round_t r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // t = SubWord(RotWord(w3)) ^ {rcon, 24'h0}, computed by the caller so that
  // the four key-schedule S-boxes can be shared between directions.
  function automatic block_t key_step_fwd(input block_t rk, input word_t t);
    word_t w0, w1, w2, w3;
    w0 = rk[127:96] ^ t;
    w1 = rk[95:64]  ^ w0;
    w2 = rk[63:32]  ^ w1;
    w3 = rk[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // t = SubWord(RotWord(w3 ^ w2)) ^ {rcon, 24'h0}
  function automatic block_t key_step_inv(input block_t rk, input word_t t);
    return {rk[127:96] ^ t,
            rk[95:64]  ^ rk[127:96],
            rk[63:32]  ^ rk[95:64],
            rk[31:0]   ^ rk[63:32]};
  endfunction

endpackage

// File: rtl/aes_decipher_iter_if.sv
// aes_decipher_iter_if: request/result bundle for the iterative AES-128 decipher.
// Latency: none. This is a wire bundle only.
// Backpressure: start is ignored while busy. Results are held until the next done.
// Signals: start/key/datain come from the requester; dataout/done/busy come from the core.
interface aes_decipher_iter_if;
  import aes_pkg::*;

  logic   start;
  block_t key;
  block_t datain;
  block_t dataout;
  logic   done;
  logic   busy;

  modport master (output start, key, datain, input dataout, done, busy);
  modport slave  (input start, key, datain, output dataout, done, busy);

endinterface

// File: rtl/aes_inv_round.sv
// aes_inv_round: one combinational AES inverse round.
// Latency: 0 cycles. The result is purely combinational.
// Backpressure: none.
// Ports: state_i (current state), rk_i (round key), last_i (skip InvMixColumns), state_o.
module aes_inv_round
  import aes_pkg::*;
(
  input  block_t state_i,
  input  block_t rk_i,
  input  logic   last_i,
  output block_t state_o
);

  block_t added;

  assign added   = inv_sub_bytes(inv_shift_rows(state_i)) ^ rk_i;
  assign state_o = last_i ? added : inv_mix_columns(added);

endmodule

// File: rtl/aes_decipher_iter.sv
// aes_decipher_iter: iterative AES-128 inverse cipher computing one round per clock.
// Latency: 20 cycles from the accepting edge to done. Throughput is one block per 21 cycles.
// Backpressure: start is sampled only in IDLE. dataout is held until the next done.
// Ports: clk, rst (async active-high), bus (slave side: start/key/datain in, dataout/done/busy out).
module aes_decipher_iter
  import aes_pkg::*;
(
  input logic                clk,
  input logic                rst,
  aes_decipher_iter_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_KEXP, ST_DEC} fsm_e;

  fsm_e   fsm_q, fsm_d;
  block_t state_q, state_d;
  block_t rk_q, rk_d;
  round_t round_q, round_d;
  block_t dataout_q, dataout_d;
  logic   done_q, done_d;

  word_t  sw_in;
  word_t  key_t;
  block_t rk_fwd;
  block_t rk_inv;
  block_t round_out;

  // The forward step rotates w3 and the inverse step rotates w3^w2. Only
  // one step runs per cycle, so a single set of four S-boxes serves both.
  assign sw_in  = (fsm_q == ST_KEXP) ? rk_q[31:0] : (rk_q[31:0] ^ rk_q[63:32]);
  assign key_t  = sub_rot_word(sw_in) ^ {rcon(round_q), 24'h0};
  assign rk_fwd = key_step_fwd(rk_q, key_t);
  assign rk_inv = key_step_inv(rk_q, key_t);

  aes_inv_round u_round (
    .state_i (state_q),
    .rk_i    (rk_inv),
    .last_i  (round_q == 4'd1),
    .state_o (round_out)
  );

  always_comb begin
    fsm_d     = fsm_q;
    state_d   = state_q;
    rk_d      = rk_q;
    round_d   = round_q;
    dataout_d = dataout_q;
    done_d    = 1'b0;
    case (fsm_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = bus.datain;
          rk_d    = bus.key;
          round_d = 4'd1;
          fsm_d   = ST_KEXP;
        end
      end
      ST_KEXP: begin
        rk_d = rk_fwd;
        if (round_q == NR) begin
          // rk_fwd is rk10 here, so the initial AddRoundKey folds into this cycle.
          state_d = state_q ^ rk_fwd;
          fsm_d   = ST_DEC;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      ST_DEC: begin
        rk_d    = rk_inv;
        round_d = round_q - 4'd1;
        if (round_q == 4'd1) begin
          dataout_d = round_out;
          done_d    = 1'b1;
          fsm_d     = ST_IDLE;
        end else begin
          state_d = round_out;
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q     <= ST_IDLE;
      state_q   <= '0;
      rk_q      <= '0;
      round_q   <= '0;
      dataout_q <= '0;
      done_q    <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      state_q   <= state_d;
      rk_q      <= rk_d;
      round_q   <= round_d;
      dataout_q <= dataout_d;
      done_q    <= done_d;
    end
  end

  assign bus.dataout = dataout_q;
  assign bus.done    = done_q;
  assign bus.busy    = (fsm_q != ST_IDLE);

endmodule

// File: tb/tb_aes_decipher_iter.sv
module tb_aes_decipher_iter;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KR = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PR = 128'he99442f8921e1e6fbf3a12537adc3d46;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  aes_decipher_iter_if dif();
  aes_decipher_iter dut (.clk(clk), .rst(rst), .bus(dif));

  int checks = 0;
  int errors = 0;
  logic [7:0] sb  [256];
  logic [7:0] isb [256];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model (textbook AES, full key schedule) ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rl8(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x};
    return t[15-n -: 8];
  endfunction

  // Walks the multiplicative group with generator 3 and its inverse in lockstep.
  task automatic gen_sbox();
    logic [7:0] p;
    logic [7:0] q;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      sb[p] = q ^ rl8(q, 1) ^ rl8(q, 2) ^ rl8(q, 3) ^ rl8(q, 4) ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
    for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
  endtask

  function automatic logic [1407:0] m_expand(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] ks;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    ks = '0;
    for (int i = 0; i < 44; i++) ks[1407-32*i -: 32] = w[i];
    return ks;
  endfunction

  function automatic logic [7:0] rkb(input logic [1407:0] ks, input int rnd, input int r, input int c);
    return ks[1407 - 32*(4*rnd + c) - 8*r -: 8];
  endfunction

  function automatic logic [7:0] imc(input int j);
    case (j)
      0: return 8'h0e;
      1: return 8'h0b;
      2: return 8'h0d;
      default: return 8'h09;
    endcase
  endfunction

  function automatic logic [7:0] fmc(input int j);
    case (j)
      0: return 8'h02;
      1: return 8'h03;
      default: return 8'h01;
    endcase
  endfunction

  function automatic logic [127:0] m_decrypt(input logic [127:0] key, input logic [127:0] ct);
    logic [1407:0] ks;
    logic [7:0]    s [4][4];
    logic [7:0]    t [4][4];
    logic [7:0]    v;
    logic [127:0]  o;
    ks = m_expand(key);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = ct[127 - 8*(4*c + r) -: 8] ^ rkb(ks, 10, r, c);
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[r][c] = isb[s[r][(c - r + 4) % 4]] ^ rkb(ks, rnd, r, c);
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) begin
          if (rnd > 0) begin
            v = 8'h00;
            for (int k = 0; k < 4; k++) v = v ^ gmul(imc((k - r + 4) % 4), t[k][c]);
            s[r][c] = v;
          end else begin
            s[r][c] = t[r][c];
          end
        end
    end
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = s[r][c];
    return o;
  endfunction

  // Stands in for aescipher in the round-trip test.
  function automatic logic [127:0] m_encrypt(input logic [127:0] key, input logic [127:0] pt);
    logic [1407:0] ks;
    logic [7:0]    s [4][4];
    logic [7:0]    t [4][4];
    logic [7:0]    v;
    logic [127:0]  o;
    ks = m_expand(key);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = pt[127 - 8*(4*c + r) -: 8] ^ rkb(ks, 0, r, c);
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[r][c] = sb[s[r][(c + r) % 4]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) begin
          if (rnd < 10) begin
            v = 8'h00;
            for (int k = 0; k < 4; k++) v = v ^ gmul(fmc((k - r + 4) % 4), t[k][c]);
          end else begin
            v = t[r][c];
          end
          s[r][c] = v ^ rkb(ks, rnd, r, c);
        end
    end
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = s[r][c];
    return o;
  endfunction

  // ---------------- transaction-level timing model ----------------
  // m_cnt counts the cycles a block still has in flight.
  int           m_cnt  = 0;
  logic         m_done = 1'b0;
  logic [127:0] m_out  = '0;
  logic [127:0] m_res  = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
      m_out  <= '0;
      m_res  <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt == 0) begin
        if (dif.start) begin
          m_cnt <= 20;
          m_res <= m_decrypt(dif.key, dif.datain);
        end
      end else if (m_cnt == 1) begin
        m_cnt  <= 0;
        m_out  <= m_res;
        m_done <= 1'b1;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_busy", 128'(dif.busy), 128'(m_cnt != 0));
    chk("cyc_done", 128'(dif.done), 128'(m_done));
    chk("cyc_dataout", dif.dataout, m_out);
  end

  // ---------------- directed stimulus ----------------
  task automatic run_block(input logic [127:0] k, input logic [127:0] ct,
                           input logic [127:0] exp, input string nm);
    int lat;
    int bcnt;
    dif.start  = 1'b1;
    dif.key    = k;
    dif.datain = ct;
    @(negedge clk);
    dif.start = 1'b0;
    bcnt = dif.busy ? 1 : 0;
    lat  = 0;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(negedge clk);
      if (dif.busy) bcnt++;
      if (dif.done) lat = n;
    end
    chk({nm, "_latency"}, 128'(lat), 128'd20);
    chk({nm, "_busy_cycles"}, 128'(bcnt), 128'd20);
    chk({nm, "_dataout"}, dif.dataout, exp);
  endtask

  initial begin
    logic [127:0] ct;
    int prev;
    int ndone;
    int lat;
    logic seen;

    dif.start  = 1'b0;
    dif.key    = '0;
    dif.datain = '0;
    gen_sbox();
    #1 rst = 1'b1;

    chk("model_sbox_00", 128'(sb[8'h00]), 128'h63);
    chk("model_sbox_53", 128'(sb[8'h53]), 128'hed);
    chk("model_dec_c1", m_decrypt(K1, C1), P1);
    chk("model_dec_b", m_decrypt(KB, CB), PB);
    chk("model_enc_c1", m_encrypt(K1, P1), C1);

    repeat (3) @(negedge clk);
    chk("reset_dataout", dif.dataout, 128'h0);
    chk("reset_done", 128'(dif.done), 128'h0);
    chk("reset_busy", 128'(dif.busy), 128'h0);
    rst = 1'b0;
    @(negedge clk);

    run_block(K1, C1, P1, "fips_c1");
    run_block(KB, CB, PB, "fips_b");
    ct = m_encrypt(KR, PR);
    run_block(KR, ct, PR, "round_trip");

    // start held high with datain changing every cycle
    dif.start = 1'b1;
    dif.key   = K1;
    prev  = -1;
    ndone = 0;
    for (int i = 0; i < 66; i++) begin
      dif.datain = C1 ^ {96'h0, 32'(i * 32'h01030507)};
      @(negedge clk);
      if (dif.done) begin
        if (prev >= 0) chk("held_done_spacing", 128'(i - prev), 128'd21);
        prev = i;
        ndone++;
      end
    end
    dif.start = 1'b0;
    chk("held_done_count", 128'(ndone), 128'd3);
    repeat (25) @(negedge clk);

    // start and new operands while busy must be ignored
    dif.start  = 1'b1;
    dif.key    = KB;
    dif.datain = CB;
    @(negedge clk);
    lat = 0;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      if (n == 5 || n == 15) begin
        dif.start  = 1'b1;
        dif.key    = ~KB;
        dif.datain = ~CB;
      end else begin
        dif.start = 1'b0;
      end
      @(negedge clk);
      if (dif.done) lat = n;
    end
    dif.start = 1'b0;
    chk("busy_ignore_latency", 128'(lat), 128'd20);
    chk("busy_ignore_dataout", dif.dataout, PB);

    // reset in the middle of the DEC phase
    dif.start  = 1'b1;
    dif.key    = K1;
    dif.datain = C1;
    @(negedge clk);
    dif.start = 1'b0;
    repeat (14) @(negedge clk);
    chk("pre_rst_busy", 128'(dif.busy), 128'h1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_dataout", dif.dataout, 128'h0);
    chk("mid_rst_done", 128'(dif.done), 128'h0);
    chk("mid_rst_busy", 128'(dif.busy), 128'h0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      if (dif.done) seen = 1'b1;
    end
    chk("no_done_after_rst", 128'(seen), 128'h0);
    run_block(K1, C1, P1, "c1_after_rst");

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    checks++;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
